dff_pipe: RTL and testbench
===========================

Name: dff_pipe

Overview:
- Parametrised elastic pipeline register built from enable-gated DFF stages.
- Each stage carries a valid bit plus a WIDTH-bit payload. Stages are coupled by a valid/ready handshake with bubble collapsing, and the whole chain has a synchronous flush.
- Used between core pipeline stages (IF->ID, ID->EX, LSU response path) where a stall or branch flush must cleanly hold or kill in-flight entries.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- DEPTH, 2, number of register stages (>=1). Stage 0 is the input side; stage DEPTH-1 drives the outputs.
- RST_VAL, {WIDTH{1'b0}}, payload value loaded on async reset and on flush.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all entries; takes priority over every other event.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  pipeline accepts in_data this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  stage DEPTH-1 holds a valid entry.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  payload of stage DEPTH-1.
- count  output  $clog2(DEPTH+1)  number of valid stages (0..DEPTH).

Behaviour:
- State per stage k: v[k] (1 bit) and d[k] (WIDTH bits).
- Async reset (rstn=0): all v[k]=0, all d[k]=RST_VAL, out_valid=0, out_data=RST_VAL, count=0. in_ready is combinational and reads 1 while reset is deasserted and flush=0.
- Ready chain (combinational, no registered ready):
  - rdy[DEPTH-1] = !v[DEPTH-1] | out_ready
  - rdy[k] = !v[k] | rdy[k+1]
  - in_ready = rdy[0] & !flush
- Stage update on a clock edge, with flush=0:
  - Stage 0 loads when rdy[0]: d[0]<=in_data, v[0]<=in_valid.
  - Stage k>0 loads when rdy[k]: d[k]<=d[k-1], v[k]<=v[k-1].
  - A stage that does not load holds v and d (CE gating).
  - A payload register loads only when its incoming valid is 1, so d holds its last value across bubbles. The v bit still clears.
- Flush (flush=1 at an edge): all v[k]<=0, all d[k]<=RST_VAL.
  - While flush=1: out_valid is forced 0 and in_ready is forced 0, so no transfer occurs on either side that cycle.
  - in_valid and out_ready are ignored.
- Transfers: an input transfer is in_valid & in_ready; an output transfer is out_valid & out_ready.
- Outputs: out_valid = v[DEPTH-1] & !flush; out_data = d[DEPTH-1].
  - Both come directly from registers, apart from the flush mask.
  - If out_valid=1 and out_ready=0, out_valid and out_data must hold stable until the transfer.
- Latency: an entry accepted at edge N into an empty pipe appears at out_valid after edge N+DEPTH-1, i.e. DEPTH cycles from in_valid to out_valid.
- Throughput: 1 entry per cycle when out_ready=1 continuously.
- Bubble collapse: an empty stage always accepts from upstream even while downstream is stalled, so a stalled pipe fills to DEPTH entries.
- Full: all v=1 and out_ready=0 -> in_ready=0.
- Full with out_ready=1 -> in_ready=1. Simultaneous push and pop shifts the whole chain and count is unchanged.
- count is registered and updated each edge: +1 on input transfer only, -1 on output transfer only, unchanged on both or neither, 0 on flush and reset. It always equals the popcount of v.
- Reset mid-operation: the async clear is immediate and independent of clk. The first edge after rstn rises behaves as an empty pipe.
- DEPTH=1: single-stage register; in_ready = !v[0] | out_ready, a full-throughput pipe register.

Decomposition:
- No package typedefs needed.
- Width helper for count: add a `CLOG2-style constant function to defines.v if one is not already present.
- One natural sub-module: dff_pipe_stage (valid + payload register with CE, async reset to RST_VAL, sync clear). It is instantiated DEPTH times in a generate loop; the ready chain and count stay in dff_pipe.

Test Plan:
- Reset: rstn=0 with in_valid=1, in_data=0xA5 -> out_valid=0, out_data=RST_VAL, count=0. Release rstn -> in_ready=1.
- Streaming, DEPTH=3, out_ready=1: push 0x11,0x22,0x33 on consecutive edges -> out_valid first asserts after the 3rd edge with 0x11, then 0x22, 0x33 on consecutive cycles. count peaks at 3.
- Stall fill, DEPTH=3, out_ready=0: push 0x01..0x04 -> first three accepted, in_ready=0 on the 4th, count=3, out_data=0x01 held stable. Raise out_ready for one cycle -> 0x04 accepted in the same cycle, count stays 3.
- Bubble collapse: push 0x10, idle 1 cycle, push 0x20, then out_ready=0 -> both entries end in adjacent stages, count=2, order preserved on drain.
- Flush: pipe full with out_ready=1 and in_valid=1, assert flush one cycle -> that cycle out_valid=0 and in_ready=0. Next cycle count=0, out_valid=0, out_data=RST_VAL, and the in_data offered during flush is never seen.
- DEPTH=1 sweep with random in_valid/out_ready for 1000 cycles -> scoreboard order and data match, no loss or duplication, count equals the number of in-flight entries every cycle.

Source files
------------

// File: rtl/dff_pipe_pkg.sv
// Shared helpers for the dff_pipe elastic pipeline register.
package dff_pipe_pkg;

  // Bits needed to hold values 0..value-1; used to size the occupancy counter.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline slot: a valid flag plus a payload register, both clock-enabled.
// The payload only captures on a valid arrival so it keeps its last value across bubbles.
module dff_pipe_stage #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             load,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Valid flag: cleared by reset or flush, otherwise follows upstream whenever the slot loads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= in_valid;
    end
  end

  // Payload: returns to RST_VAL on reset/flush and only captures real entries.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data <= RST_VAL;
    end else if (clear) begin
      data <= RST_VAL;
    end else if (load && in_valid) begin
      data <= in_data;
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// Elastic valid/ready pipeline of DEPTH register slots with bubble collapsing,
// a synchronous flush that kills every entry, and a registered occupancy count.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [clog2(DEPTH+1)-1:0]     count
);

  localparam int CW = clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] d [DEPTH];
  logic             push;
  logic             pop;

  // Ready ripples from the output back to the input: a slot can load if it is
  // empty or everything downstream of it is about to move.
  always_comb begin
    rdy = '0;
    rdy[DEPTH-1] = !v[DEPTH-1] | out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      rdy[k] = !v[k] | rdy[k+1];
    end
  end

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic             up_valid;
      logic [WIDTH-1:0] up_data;

      if (k == 0) begin : g_head
        assign up_valid = in_valid;
        assign up_data  = in_data;
      end else begin : g_body
        assign up_valid = v[k-1];
        assign up_data  = d[k-1];
      end

      dff_pipe_stage #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_stage (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (flush),
        .load     (rdy[k]),
        .in_valid (up_valid),
        .in_data  (up_data),
        .valid    (v[k]),
        .data     (d[k])
      );
    end
  endgenerate

  assign in_ready  = rdy[0] & !flush;
  assign out_valid = v[DEPTH-1] & !flush;
  assign out_data  = d[DEPTH-1];

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Occupancy tracks push/pop so it always matches the number of valid slots.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CW'(1);
    end else if (pop && !push) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: a DEPTH=3 instance driven by directed vectors and a
// DEPTH=1 instance driven by a random sweep, both checked against a slot-position model.
module tb_dff_pipe;

  localparam logic [7:0] RST_A = 8'hE7;
  localparam logic [7:0] RST_B = 8'h00;

  logic clk = 1'b0;
  logic rstn = 1'b1;

  logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_count;

  logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [0:0] b_count;

  int total = 0;
  int bad = 0;

  // Model: per instance, the slot position of every in-flight entry (oldest first).
  int         m_pos [2][4];
  logic [7:0] m_dat [2][4];
  int         m_n   [2];
  logic [7:0] m_last[2];

  dff_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(RST_A)) u_a (
    .clk(clk), .rstn(rstn), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count)
  );

  dff_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(RST_B)) u_b (
    .clk(clk), .rstn(rstn), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n[0] = 0;
    m_n[1] = 0;
    m_last[0] = RST_A;
    m_last[1] = RST_B;
  endtask

  function automatic logic model_in_ready(input int i, input int depth, input logic ordy, input logic fl);
    if (fl) return 1'b0;
    if (m_n[i] < depth) return 1'b1;
    return (m_pos[i][0] == depth - 1) && ordy;
  endfunction

  // Advance one instance by one clock edge using entry positions only.
  task automatic model_step(input int i, input int depth, input logic iv, input logic [7:0] idat,
                            input logic ordy, input logic fl);
    logic rdy;
    int   prev;
    int   np;
    if (fl) begin
      m_n[i] = 0;
      m_last[i] = (i == 0) ? RST_A : RST_B;
      return;
    end
    rdy = model_in_ready(i, depth, ordy, fl);
    if (m_n[i] > 0 && m_pos[i][0] == depth - 1 && ordy) begin
      for (int j = 0; j < m_n[i] - 1; j++) begin
        m_pos[i][j] = m_pos[i][j+1];
        m_dat[i][j] = m_dat[i][j+1];
      end
      m_n[i] = m_n[i] - 1;
    end
    prev = depth;
    for (int j = 0; j < m_n[i]; j++) begin
      np = m_pos[i][j] + 1;
      if (np > prev - 1) np = prev - 1;
      if (np == depth - 1 && m_pos[i][j] != depth - 1) m_last[i] = m_dat[i][j];
      m_pos[i][j] = np;
      prev = np;
    end
    if (iv && rdy) begin
      m_pos[i][m_n[i]] = 0;
      m_dat[i][m_n[i]] = idat;
      m_n[i] = m_n[i] + 1;
      if (depth == 1) m_last[i] = idat;
    end
  endtask

  // Model state follows the DUT's async reset and clock edges.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      model_reset();
    end else begin
      model_step(0, 3, a_in_valid, a_in_data, a_out_ready, a_flush);
      model_step(1, 1, b_in_valid, b_in_data, b_out_ready, b_flush);
    end
  end

  task automatic compare_inst(input int i, input int depth, input logic fl, input logic ordy,
                              input logic ov, input logic [7:0] od, input logic ir, input logic [1:0] cnt);
    logic exp_valid;
    exp_valid = (m_n[i] > 0) && (m_pos[i][0] == depth - 1) && !fl;
    check_output($sformatf("model_out_valid[%0d]", i), 32'(ov), 32'(exp_valid));
    check_output($sformatf("model_out_data[%0d]", i), 32'(od), 32'(m_last[i]));
    check_output($sformatf("model_in_ready[%0d]", i), 32'(ir), 32'(model_in_ready(i, depth, ordy, fl)));
    check_output($sformatf("model_count[%0d]", i), 32'(cnt), 32'(m_n[i]));
    if (exp_valid && ov === 1'b1)
      check_output($sformatf("model_head[%0d]", i), 32'(od), 32'(m_dat[i][0]));
  endtask

  // Every falling edge, both instances are compared against the model.
  always @(negedge clk) begin
    compare_inst(0, 3, a_flush, a_out_ready, a_out_valid, a_out_data, a_in_ready, a_count);
    compare_inst(1, 1, b_flush, b_out_ready, b_out_valid, b_out_data, b_in_ready, {1'b0, b_count});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic iv, input logic [7:0] idat, input logic ordy, input logic fl);
    a_in_valid  = iv;
    a_in_data   = idat;
    a_out_ready = ordy;
    a_flush     = fl;
  endtask

  task automatic check_a(input string tag, input logic ov, input logic [7:0] od, input logic [1:0] cnt);
    #1;
    check_output({tag, "_out_valid"}, 32'(a_out_valid), 32'(ov));
    check_output({tag, "_out_data"}, 32'(a_out_data), 32'(od));
    check_output({tag, "_count"}, 32'(a_count), 32'(cnt));
  endtask

  initial begin
    model_reset();
    apply_stimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    b_flush = 1'b0; b_in_valid = 1'b1; b_in_data = 8'hA5; b_out_ready = 1'b0;
    #2 rstn = 1'b0;

    // Reset holds everything empty even with a valid input offered.
    repeat (2) step();
    check_a("reset", 1'b0, RST_A, 2'd0);
    check_output("reset_b_out_data", 32'(b_out_data), 32'(RST_B));
    rstn = 1'b1;
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    b_in_valid = 1'b0;
    #1;
    check_output("release_in_ready_a", 32'(a_in_ready), 32'd1);
    check_output("release_in_ready_b", 32'(b_in_ready), 32'd1);

    // Streaming 0x11,0x22,0x33 through DEPTH=3 with out_ready high.
    step(); apply_stimulus(1'b1, 8'h11, 1'b1, 1'b0);
    step(); apply_stimulus(1'b1, 8'h22, 1'b1, 1'b0);
    step(); apply_stimulus(1'b1, 8'h33, 1'b1, 1'b0);
    check_a("stream_e2", 1'b0, RST_A, 2'd2);
    step(); apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_a("stream_e3", 1'b1, 8'h11, 2'd3);
    step(); check_a("stream_e4", 1'b1, 8'h22, 2'd2);
    step(); check_a("stream_e5", 1'b1, 8'h33, 2'd1);
    step(); check_a("stream_e6", 1'b0, 8'h33, 2'd0);

    // Stall fill: 0x01..0x03 fill the pipe, 0x04 waits for a pop.
    apply_stimulus(1'b1, 8'h01, 1'b0, 1'b0);
    step(); apply_stimulus(1'b1, 8'h02, 1'b0, 1'b0);
    step(); apply_stimulus(1'b1, 8'h03, 1'b0, 1'b0);
    step(); apply_stimulus(1'b1, 8'h04, 1'b0, 1'b0);
    check_a("stall_full", 1'b1, 8'h01, 2'd3);
    check_output("stall_in_ready", 32'(a_in_ready), 32'd0);
    step(); check_a("stall_hold", 1'b1, 8'h01, 2'd3);
    apply_stimulus(1'b1, 8'h04, 1'b1, 1'b0);
    #1 check_output("stall_pushpop_ready", 32'(a_in_ready), 32'd1);
    step(); apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check_a("stall_pushpop", 1'b1, 8'h02, 2'd3);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    step(); check_a("stall_drain1", 1'b1, 8'h03, 2'd2);
    step(); check_a("stall_drain2", 1'b1, 8'h04, 2'd1);
    step(); check_a("stall_drain3", 1'b0, 8'h04, 2'd0);

    // Bubble collapse: 0x10, idle, 0x20 with downstream stalled.
    apply_stimulus(1'b1, 8'h10, 1'b0, 1'b0);
    step(); apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    step(); apply_stimulus(1'b1, 8'h20, 1'b0, 1'b0);
    step(); apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check_a("bubble_e3", 1'b1, 8'h10, 2'd2);
    step(); check_a("bubble_packed", 1'b1, 8'h10, 2'd2);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    step(); check_a("bubble_drain1", 1'b1, 8'h20, 2'd1);
    step(); check_a("bubble_drain2", 1'b0, 8'h20, 2'd0);

    // Flush a full pipe while both sides want to transfer.
    apply_stimulus(1'b1, 8'hA1, 1'b0, 1'b0);
    step(); apply_stimulus(1'b1, 8'hA2, 1'b0, 1'b0);
    step(); apply_stimulus(1'b1, 8'hA3, 1'b0, 1'b0);
    step(); apply_stimulus(1'b1, 8'hBB, 1'b1, 1'b1);
    #1;
    check_output("flush_out_valid", 32'(a_out_valid), 32'd0);
    check_output("flush_in_ready", 32'(a_in_ready), 32'd0);
    step(); apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_a("flush_after", 1'b0, RST_A, 2'd0);
    step(); check_a("flush_after2", 1'b0, RST_A, 2'd0);

    // Async reset in the middle of operation.
    apply_stimulus(1'b1, 8'hC1, 1'b0, 1'b0);
    step(); apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    check_a("midrst_before", 1'b0, RST_A, 2'd1);
    rstn = 1'b0;
    check_a("midrst_async", 1'b0, RST_A, 2'd0);
    step(); rstn = 1'b1;
    step(); check_a("midrst_after", 1'b0, RST_A, 2'd0);

    // DEPTH=1 pins: one entry sits until out_ready, full-throughput register.
    b_in_valid = 1'b1; b_in_data = 8'h77; b_out_ready = 1'b0;
    step(); b_in_valid = 1'b0;
    #1;
    check_output("d1_out_valid", 32'(b_out_valid), 32'd1);
    check_output("d1_out_data", 32'(b_out_data), 32'h77);
    check_output("d1_count", 32'(b_count), 32'd1);
    check_output("d1_in_ready_full", 32'(b_in_ready), 32'd0);
    b_out_ready = 1'b1;
    #1 check_output("d1_in_ready_pop", 32'(b_in_ready), 32'd1);

    // DEPTH=1 random sweep; the per-cycle model compare covers order and count.
    for (int n = 0; n < 1000; n++) begin
      step();
      b_in_valid  = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
      b_in_data   = 8'($urandom);
      b_flush     = ($urandom_range(0, 49) == 0);
    end
    step();
    b_in_valid = 1'b0; b_flush = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
